// File: rtl/boot_loader_if.sv
// Byte-stream input and memory/cpu-control outputs of the program loader.
// The loader drives the slave side; the stream source and memory sit on the master side.
interface boot_loader_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 48
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic [ADDR_W-1:0] start_addr;
    logic              done;
    logic              error;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, start_addr, done, error
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, start_addr, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Decodes framed load records from a byte stream into memory writes and holds
// the cpu in reset until a valid start record has been accepted.
module boot_loader #(
    parameter int         ADDR_W     = 15,
    parameter int         WORD_BYTES = 6,
    parameter int         WORD_W     = 48,
    parameter logic [7:0] SYNC       = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    boot_loader_if.slave  bus
);
    localparam int BW = $clog2(WORD_BYTES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_TYPE, S_ADDR2, S_ADDR1, S_ADDR0, S_COUNT, S_DATA, S_CSUM, S_RUN, S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              active, xfer;

    // Held low during reset so the source never sees a transfer it could lose.
    assign active       = (state_q != S_RUN) && (state_q != S_FAIL);
    assign bus.in_ready = reset && active;
    assign xfer         = bus.in_valid && bus.in_ready;

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.start_addr = start_addr_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.cpu_reset  = cpu_reset_q;

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        start_d      = start_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        start_addr_d = start_addr_q;
        done_d       = done_q;
        error_d      = error_q;
        cpu_reset_d  = cpu_reset_q;
        if (xfer) begin
            sum_d = sum_q + bus.in_data;
            case (state_q)
                S_IDLE: if (bus.in_data == SYNC) begin
                    state_d = S_TYPE;
                    sum_d   = '0;
                end
                S_TYPE: begin
                    start_d = (bus.in_data == 8'h02);
                    if (bus.in_data == 8'h01 || bus.in_data == 8'h02) state_d = S_ADDR2;
                    else                                                 state_d = S_FAIL;
                end
                // Address bytes shift in; the register width truncates the upper bits.
                S_ADDR2: begin addr_d = ADDR_W'(bus.in_data);         state_d = S_ADDR1; end
                S_ADDR1: begin addr_d = ADDR_W'({addr_q, bus.in_data}); state_d = S_ADDR0; end
                S_ADDR0: begin addr_d = ADDR_W'({addr_q, bus.in_data}); state_d = S_COUNT; end
                S_COUNT: begin
                    if (start_q) begin
                        state_d = (bus.in_data == 8'h00) ? S_CSUM : S_FAIL;
                    end else begin
                        cnt_d   = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
                        byte_d  = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d = {word_q[WORD_W-9:0], bus.in_data};
                    if (byte_q == BW'(WORD_BYTES - 1)) begin
                        byte_d      = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = word_d;
                        addr_d      = addr_q + 1'b1;
                        cnt_d       = cnt_q - 9'd1;
                        if (cnt_q == 9'd1) state_d = S_CSUM;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
                S_CSUM: begin
                    if (sum_d != 8'h00) begin
                        state_d = S_FAIL;
                    end else if (start_q) begin
                        state_d      = S_RUN;
                        start_addr_d = addr_q;
                        done_d       = 1'b1;
                        cpu_reset_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
            if (state_d == S_FAIL) error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sum_q        <= '0;
            start_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            word_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            start_addr_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            start_q      <= start_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            word_q       <= word_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            start_addr_q <= start_addr_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Randomised and directed record streams checked against a record-level parsing model.
module tb_boot_loader;
    localparam int AW = 15;
    localparam int WW = 48;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();
    boot_loader #(.ADDR_W(AW), .WORD_BYTES(6), .WORD_W(WW), .SYNC(8'hA5)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  stream_q[$];
    logic [63:0] obs_w[$];
    logic [63:0] exp_w[$];
    bit          exp_done, exp_err;
    logic [AW-1:0] exp_start;
    int          exp_acc, acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk)
        if (reset && bus.mem_we) obs_w.push_back({1'b0, bus.mem_addr, bus.mem_wdata});

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record-level model: walks the byte list and predicts writes, final flags and
    // how many bytes the loader accepts before it stops taking input.
    task automatic model_run();
        int n, i, nw;
        logic [7:0] t, c, sum;
        logic [23:0] a;
        logic [AW-1:0] wa;
        logic [WW-1:0] word;
        bit fin;
        n = stream_q.size(); i = 0; fin = 0;
        exp_w.delete(); exp_done = 0; exp_err = 0; exp_start = '0; exp_acc = n;
        while (i < n && !fin) begin
            if (stream_q[i] != 8'hA5) begin i++; continue; end
            i++;
            if (i >= n) break;
            t = stream_q[i]; i++; sum = t;
            if (t != 8'h01 && t != 8'h02) begin exp_err = 1; exp_acc = i; break; end
            if (n - i < 4) break;
            a = {stream_q[i], stream_q[i+1], stream_q[i+2]};
            c = stream_q[i+3];
            sum = sum + a[23:16] + a[15:8] + a[7:0] + c;
            i += 4;
            wa = a[AW-1:0];
            if (t == 8'h02) begin
                if (c != 8'h00) begin exp_err = 1; exp_acc = i; break; end
                if (i >= n) break;
                sum = sum + stream_q[i]; i++;
                if (sum != 8'h00) exp_err = 1;
                else begin exp_done = 1; exp_start = wa; end
                exp_acc = i;
                break;
            end
            nw = (c == 8'h00) ? 256 : int'(c);
            for (int w = 0; w < nw; w++) begin
                if (n - i < 6) begin fin = 1; break; end
                word = '0;
                for (int k = 0; k < 6; k++) begin
                    word = {word[WW-9:0], stream_q[i+k]};
                    sum  = sum + stream_q[i+k];
                end
                exp_w.push_back({1'b0, wa, word});
                wa = wa + 1'b1;
                i += 6;
            end
            if (fin || i >= n) break;
            sum = sum + stream_q[i]; i++;
            if (sum != 8'h00) begin exp_err = 1; exp_acc = i; break; end
        end
    endtask

    task automatic reset_dut(input bit check);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;
        obs_w.delete();
        repeat (3) @(posedge clk);
        if (check) begin
            @(negedge clk);
            chk("rst.in_ready",   bus.in_ready,   0);
            chk("rst.cpu_reset",  bus.cpu_reset,  1);
            chk("rst.mem_we",     bus.mem_we,     0);
            chk("rst.done",       bus.done,       0);
            chk("rst.error",      bus.error,      0);
            chk("rst.mem_addr",   bus.mem_addr,   0);
            chk("rst.start_addr", bus.start_addr, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        if (check) begin
            @(negedge clk);
            chk("rel.in_ready",  bus.in_ready,  1);
            chk("rel.cpu_reset", bus.cpu_reset, 1);
            @(posedge clk); #1;
        end
    endtask

    // Returns 0 if the loader never took the byte within the wait bound.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit r;
        int k;
        bus.in_data = b; bus.in_valid = 1'b1;
        k = 0; ok = 1;
        forever begin
            @(negedge clk); r = bus.in_ready;
            @(posedge clk); #1;
            if (r) break;
            k++;
            if (k > 20) begin ok = 0; break; end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // gmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic send_stream(input int gmode);
        bit ok;
        int gap;
        acc = 0;
        for (int i = 0; i < stream_q.size(); i++) begin
            gap = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
            send_byte(stream_q[i], gap, ok);
            if (!ok) break;
            acc++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_run(input string tag);
        int m;
        model_run();
        @(negedge clk);
        chk({tag, ".nwrites"}, obs_w.size(), exp_w.size());
        m = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s.wr%0d", tag, i), obs_w[i], exp_w[i]);
        chk({tag, ".done"},       bus.done,       exp_done);
        chk({tag, ".error"},      bus.error,      exp_err);
        chk({tag, ".cpu_reset"},  bus.cpu_reset,  !exp_done);
        chk({tag, ".start_addr"}, bus.start_addr, exp_start);
        chk({tag, ".accepted"},   acc,            exp_acc);
        chk({tag, ".in_ready"},   bus.in_ready,   !(exp_done || exp_err));
        @(posedge clk); #1;
    endtask

    task automatic push_data_rec(input logic [23:0] a, input logic [7:0] cnt, input bit bad);
        logic [7:0] sum, b;
        int nw;
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'h01);
        stream_q.push_back(a[23:16]);
        stream_q.push_back(a[15:8]);
        stream_q.push_back(a[7:0]);
        stream_q.push_back(cnt);
        sum = 8'h01 + a[23:16] + a[15:8] + a[7:0] + cnt;
        nw = (cnt == 8'h00) ? 256 : int'(cnt);
        for (int i = 0; i < nw * 6; i++) begin
            b = 8'($urandom);
            stream_q.push_back(b);
            sum = sum + b;
        end
        stream_q.push_back(8'(8'h00 - sum + {7'd0, bad}));
    endtask

    task automatic push_start_rec(input logic [23:0] a, input logic [7:0] cnt);
        logic [7:0] sum;
        sum = 8'h02 + a[23:16] + a[15:8] + a[7:0] + cnt;
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'h02);
        stream_q.push_back(a[23:16]);
        stream_q.push_back(a[15:8]);
        stream_q.push_back(a[7:0]);
        stream_q.push_back(cnt);
        stream_q.push_back(8'(8'h00 - sum));
    endtask

    task automatic push_case2(input logic [7:0] csum);
        logic [7:0] c2 [12] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2A};
        for (int i = 0; i < 12; i++) stream_q.push_back(c2[i]);
        stream_q.push_back(csum);
    endtask

    task automatic push_case3();
        logic [7:0] c3 [7] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h20, 8'h00, 8'hDE};
        for (int i = 0; i < 7; i++) stream_q.push_back(c3[i]);
    endtask

    initial begin
        bit ok;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state, then the basic data record.
        reset_dut(1);
        stream_q.delete(); push_case2(8'hC4);
        send_stream(0);
        check_run("c2");
        chk("c2.addr_abs", obs_w.size() > 0 ? obs_w[0] : 64'h0, {1'b0, 15'h0010, 48'h00000000002A});

        // Data record followed by start record.
        reset_dut(0);
        stream_q.delete(); push_case2(8'hC4); push_case3();
        send_stream(0);
        check_run("c3");
        chk("c3.start_abs", bus.start_addr, 15'h0020);

        // Bad checksum: word still committed, then error; start record refused.
        reset_dut(0);
        stream_q.delete(); push_case2(8'hC5); push_case3();
        send_stream(0);
        check_run("c4");

        // Address wrap at the top of the memory.
        reset_dut(0);
        stream_q.delete(); push_data_rec(24'h007FFF, 8'd2, 0);
        send_stream(0);
        check_run("c5");

        // Leading garbage and valid toggling every other cycle.
        reset_dut(0);
        stream_q.delete(); stream_q.push_back(8'h00); stream_q.push_back(8'hFF); push_case2(8'hC4);
        send_stream(1);
        check_run("c6");

        // Reset right after the last byte of a word: the write must not appear.
        reset_dut(0);
        stream_q.delete(); push_data_rec(24'h000040, 8'd2, 0);
        for (int i = 0; i < 12; i++) send_byte(stream_q[i], 0, ok);
        reset_dut(0);
        @(negedge clk);
        chk("midrst.nwrites", obs_w.size(), 0);
        chk("midrst.in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        stream_q.delete(); push_case2(8'hC4);
        send_stream(0);
        check_run("midrst.after");

        // COUNT 0 means 256 words.
        reset_dut(0);
        stream_q.delete(); push_data_rec(24'h007F80, 8'd0, 0);
        send_stream(0);
        check_run("cnt256");

        // Start record with non-zero count, and an unknown record type.
        reset_dut(0);
        stream_q.delete(); push_start_rec(24'h000100, 8'd1); push_case3();
        send_stream(0);
        check_run("startcnt");
        reset_dut(0);
        stream_q.delete(); stream_q.push_back(8'hA5); stream_q.push_back(8'h07); push_case2(8'hC4);
        send_stream(0);
        check_run("badtype");

        // Random record mixes with random gaps.
        for (int it = 0; it < 6; it++) begin
            reset_dut(0);
            stream_q.delete();
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    logic [7:0] gb;
                    gb = 8'($urandom);
                    stream_q.push_back(gb == 8'hA5 ? 8'h00 : gb);
                end
                push_data_rec(24'($urandom), 8'($urandom_range(1, 4)), $urandom_range(0, 5) == 0);
            end
            push_start_rec(24'($urandom), 8'h00);
            send_stream(2);
            check_run($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
